// File: rtl/microaddress_sequencer_if.sv
// Bus between the next-state address selector / control register and the
// microaddress sequencer. master = selector side, slave = sequencer.
interface microaddress_sequencer_if #(
  parameter int unsigned ADDR_W = 7
);
  logic [1:0]        mux_select;
  logic [ADDR_W-1:0] enc_addr;
  logic [ADDR_W-1:0] cr_addr;
  logic              hold;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] upc;
  logic [ADDR_W-1:0] incr_addr;
  logic              stk_err;

  modport master (
    output mux_select, enc_addr, cr_addr, hold, call, ret,
    input  upc, incr_addr, stk_err
  );

  modport slave (
    input  mux_select, enc_addr, cr_addr, hold, call, ret,
    output upc, incr_addr, stk_err
  );
endinterface

// File: rtl/microaddress_sequencer.sv
// Microaddress sequencer: selects the next microinstruction address from
// encoder / fetch / control-register / incrementer sources and registers it
// as upc, with upc+1 kept in a separate incrementer register. A hold input
// freezes all state during memory wait states.
// Optional microsubroutine return stack enabled by defining USTACK_EN.
module microaddress_sequencer #(
  parameter int unsigned       ADDR_W      = 7,
  parameter logic [ADDR_W-1:0] FETCH_ADDR  = '0,
  parameter int unsigned       STACK_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  microaddress_sequencer_if.slave       bus
);

  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [ADDR_W-1:0] incr_q, incr_d;
  logic [ADDR_W-1:0] mux_addr;
  logic [ADDR_W-1:0] next_addr;

  // Source mux; any non-decoded select value falls back to the fetch address
  always_comb begin
    mux_addr = FETCH_ADDR;
    unique case (bus.mux_select)
      2'b00:   mux_addr = bus.enc_addr;
      2'b01:   mux_addr = FETCH_ADDR;
      2'b10:   mux_addr = bus.cr_addr;
      2'b11:   mux_addr = incr_q;
      default: mux_addr = FETCH_ADDR;
    endcase
  end

`ifdef USTACK_EN
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  logic [STACK_DEPTH-1:0][ADDR_W-1:0] stk_q, stk_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               err_q, err_d;
  logic [CNT_W-1:0]                   top_idx;
  logic [ADDR_W-1:0]                  top_val;
  logic                               do_call, do_ret, conflict;
  logic                               full, empty;

  assign do_call  = bus.call & ~bus.ret;
  assign do_ret   = bus.ret & ~bus.call;
  assign conflict = bus.call & bus.ret;
  assign full     = (cnt_q == CNT_W'(STACK_DEPTH));
  assign empty    = (cnt_q == '0);
  assign top_idx  = cnt_q - 1'b1;

  // Read the newest stack entry; loop select keeps index widths matched
  always_comb begin
    top_val = FETCH_ADDR;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (CNT_W'(i) == top_idx) top_val = stk_q[i];
    end
  end

  // Next address: a valid return overrides the mux, an empty return goes to fetch
  always_comb begin
    next_addr = mux_addr;
    if (do_ret) next_addr = empty ? FETCH_ADDR : top_val;
  end

  // Stack push/pop and sticky error; everything frozen under hold
  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (!bus.hold) begin
      if (conflict) begin
        err_d = 1'b1;
      end else if (do_call) begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < STACK_DEPTH; i++) begin
            if (CNT_W'(i) == cnt_q) stk_d[i] = incr_q;
          end
          cnt_d = cnt_q + 1'b1;
        end
      end else if (do_ret) begin
        if (empty) err_d = 1'b1;
        else       cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Stack state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      stk_q <= stk_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.stk_err = err_q;
`else
  // Stack removed: call/ret have no effect and the error flag is constant
  localparam int unsigned UNUSED_DEPTH = STACK_DEPTH;
  logic unused_stack_ctl;
  assign unused_stack_ctl = bus.call ^ bus.ret;

  // Next address comes straight from the mux
  always_comb begin
    next_addr = mux_addr;
  end

  assign bus.stk_err = 1'b0;
`endif

  // Address and incrementer update; hold keeps both registers
  always_comb begin
    upc_d  = upc_q;
    incr_d = incr_q;
    if (!bus.hold) begin
      upc_d  = next_addr;
      incr_d = next_addr + ADDR_W'(1);
    end
  end

  // upc / incrementer registers, reset to the fetch state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc_q  <= FETCH_ADDR;
      incr_q <= FETCH_ADDR + ADDR_W'(1);
    end else begin
      upc_q  <= upc_d;
      incr_q <= incr_d;
    end
  end

  assign bus.upc       = upc_q;
  assign bus.incr_addr = incr_q;

endmodule

// File: tb/tb_microaddress_sequencer.sv
// Bench for microaddress_sequencer: directed scenarios followed by random
// traffic, compared against an arithmetic model with a queue-based stack.
module tb_microaddress_sequencer;
  localparam int AW    = 7;
  localparam int MODV  = 1 << AW;
  localparam int FETCH = 0;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  // reference model state
  int m_upc;
  bit m_err;
  int m_stk[$];

  microaddress_sequencer_if #(.ADDR_W(AW)) bus ();

  microaddress_sequencer #(
    .ADDR_W(AW), .FETCH_ADDR(7'(FETCH)), .STACK_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_all(input string tag);
    int exp_incr;
    exp_incr = (m_upc + 1) % MODV;
    checks++;
    assert (bus.upc === 7'(m_upc)) else begin
      failures++;
      $error("FAIL %s upc got=%0h exp=%0h", tag, bus.upc, m_upc);
    end
    checks++;
    assert (bus.incr_addr === 7'(exp_incr)) else begin
      failures++;
      $error("FAIL %s incr_addr got=%0h exp=%0h", tag, bus.incr_addr, exp_incr);
    end
    checks++;
    assert (bus.stk_err === m_err) else begin
      failures++;
      $error("FAIL %s stk_err got=%0b exp=%0b", tag, bus.stk_err, m_err);
    end
  endtask

  // Apply inputs, advance the model by the behavioural rules, take one edge, check.
  task automatic step(input int sel, input int enc, input int cr, input bit hld,
                      input bit cl, input bit rt, input string tag);
    int mux, nxt;
    bus.mux_select = 2'(sel);
    bus.enc_addr   = 7'(enc);
    bus.cr_addr    = 7'(cr);
    bus.hold       = hld;
    bus.call       = cl;
    bus.ret        = rt;
    case (sel)
      0: mux = enc;
      1: mux = FETCH;
      2: mux = cr;
      default: mux = (m_upc + 1) % MODV;
    endcase
    if (!hld) begin
      nxt = mux;
`ifdef USTACK_EN
      if (cl && rt) m_err = 1'b1;
      else if (rt) begin
        if (m_stk.size() > 0) nxt = m_stk.pop_back();
        else begin nxt = FETCH; m_err = 1'b1; end
      end else if (cl) begin
        if (m_stk.size() < DEPTH) m_stk.push_back((m_upc + 1) % MODV);
        else m_err = 1'b1;
      end
`endif
      m_upc = nxt;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Async reset asserted mid-cycle, checked before any edge, released on negedge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    m_upc = FETCH;
    m_err = 1'b0;
    m_stk.delete();
    #1;
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.mux_select = 2'b01;
    bus.enc_addr = '0;
    bus.cr_addr = '0;
    bus.hold = 1'b0;
    bus.call = 1'b0;
    bus.ret = 1'b0;
    m_upc = FETCH;
    m_err = 1'b0;
    #12;
    check_all("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // 1: run, async reset mid-run, then count up
    step(2, 0, 7'h33, 0, 0, 0, "pre_reset_jump");
    do_reset("async_reset");
    step(3, 0, 0, 0, 0, 0, "inc1");
    step(3, 0, 0, 0, 0, 0, "inc2");
    step(3, 0, 0, 0, 0, 0, "inc3");

    // 2: encoder and control-register sources, fetch source
    step(0, 7'h2A, 0, 0, 0, 0, "enc_src");
    step(2, 0, 7'h10, 0, 0, 0, "cr_src");
    step(1, 7'h11, 7'h22, 0, 0, 0, "fetch_src");

    // 3: incrementer wrap
    step(2, 0, 7'h7F, 0, 0, 0, "to_7f");
    step(3, 0, 0, 0, 0, 0, "wrap");

    // 4: hold for three edges, then release; also reset during hold
    step(2, 0, 7'h55, 1, 0, 0, "hold1");
    step(2, 0, 7'h55, 1, 0, 0, "hold2");
    step(2, 0, 7'h55, 1, 1, 1, "hold3");
    step(2, 0, 7'h55, 0, 0, 0, "hold_release");
    bus.hold = 1'b1;
    do_reset("reset_in_hold");

`ifdef USTACK_EN
    // 5: call / return / return on empty
    step(2, 0, 7'h20, 0, 0, 0, "to_20");
    step(2, 0, 7'h40, 0, 1, 0, "call_40");
    step(2, 0, 7'h70, 0, 0, 1, "ret_21");
    step(2, 0, 7'h70, 0, 0, 1, "ret_empty");
    step(3, 0, 0, 0, 0, 0, "err_sticky");
    do_reset("reset_clears_err");

    // 6: overflow on fifth call, four returns newest-first
    for (int i = 0; i < 5; i++) step(2, 0, 7'h10 * (i + 1), 0, 1, 0, "call_chain");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, "ret_chain");
    step(2, 0, 7'h05, 0, 1, 1, "call_ret_conflict");
    do_reset("reset_after_stack");
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rand_reset");
      end else begin
        step($urandom_range(0, 3), $urandom_range(0, MODV - 1), $urandom_range(0, MODV - 1),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 4) == 0), "random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
